// File: rtl/alu_seq_nbits_if.sv
// rtl/alu_seq_nbits_if.sv - operand/result handshake bundle for the sequential N-bit ALU
interface alu_seq_nbits_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         neg_flag;
    logic         zr_flag;
    logic         cry_flag;
    logic         of_flag;
    logic         err_flag;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, neg_flag, zr_flag, cry_flag, of_flag, err_flag
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, neg_flag, zr_flag, cry_flag, of_flag, err_flag
    );
endinterface

// File: rtl/alu_seq_nbits.sv
// rtl/alu_seq_nbits.sv - registered handshaked N-bit ALU with iterative mul/div/mod
module alu_seq_nbits #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_nbits_if.slave bus
);
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_next;
    logic [3:0]     op_q;
    logic [N-1:0]   a_q, b_q;
    logic [2*N-1:0] wrk, wrk_step;
    logic [SW-1:0]  cnt;
    logic [N-1:0]   res_q;
    logic           neg_q, zr_q, cry_q, of_q, err_q;
    logic           accept, multi, last, load;
    logic [N-1:0]   fin_res;
    logic           fin_cry, fin_of, fin_err;
    logic [N:0]     sum_w, dif_w, shl_w, shr_w;
    logic [N:0]     prod_add, rem_sh, trial;
    logic [SW-1:0]  k;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign accept = bus.in_valid && (state == IDLE);
    assign multi  = (bus.op >= 4'd7) && (bus.op <= 4'd9);
    assign last   = (state == BUSY) && (cnt == SW'(N - 1));
    assign load   = (accept && !multi) || last;

    assign bus.result   = res_q;
    assign bus.neg_flag = neg_q;
    assign bus.zr_flag  = zr_q;
    assign bus.cry_flag = cry_q;
    assign bus.of_flag  = of_q;
    assign bus.err_flag = err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = multi ? BUSY : DONE;
            BUSY:    if (last) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One iteration: wrk holds {acc_hi, multiplier} for mul, {remainder, dividend/quotient} for div/mod
    always_comb begin
        prod_add = {1'b0, wrk[2*N-1:N]} + (wrk[0] ? {1'b0, a_q} : '0);
        rem_sh   = {wrk[2*N-1:N], wrk[N-1]};
        trial    = rem_sh - {1'b0, b_q};
        if (op_q == 4'd7)
            wrk_step = {prod_add, wrk[N-1:1]};
        else if (!trial[N])
            wrk_step = {trial[N-1:0], wrk[N-2:0], 1'b1};
        else
            wrk_step = {rem_sh[N-1:0], wrk[N-2:0], 1'b0};
    end

    always_comb begin
        k       = bus.b[SW-1:0];
        sum_w   = {1'b0, bus.a} + {1'b0, bus.b};
        dif_w   = {1'b0, bus.a} - {1'b0, bus.b};
        shl_w   = {1'b0, bus.a} << k;
        shr_w   = {bus.a, 1'b0} >> k;
        fin_res = '0;
        fin_cry = 1'b0;
        fin_of  = 1'b0;
        fin_err = 1'b0;
        if (state == BUSY) begin
            case (op_q)
                4'd7: begin
                    fin_res = wrk_step[N-1:0];
                    fin_cry = |wrk_step[2*N-1:N];
                    fin_of  = |wrk_step[2*N-1:N];
                end
                4'd8: begin
                    fin_res = (b_q == '0) ? '1 : wrk_step[N-1:0];
                    fin_of  = (b_q == '0);
                end
                default: begin
                    fin_res = (b_q == '0) ? a_q : wrk_step[2*N-1:N];
                    fin_of  = (b_q == '0);
                end
            endcase
        end else begin
            case (bus.op)
                4'd0: begin
                    fin_res = sum_w[N-1:0];
                    fin_cry = sum_w[N];
                    fin_of  = (bus.a[N-1] == bus.b[N-1]) && (sum_w[N-1] != bus.a[N-1]);
                end
                4'd1: begin
                    fin_res = dif_w[N-1:0];
                    fin_cry = dif_w[N];
                    fin_of  = (bus.a[N-1] != bus.b[N-1]) && (dif_w[N-1] != bus.a[N-1]);
                end
                4'd2: fin_res = bus.a & bus.b;
                4'd3: fin_res = bus.a | bus.b;
                4'd4: fin_res = bus.a ^ bus.b;
                4'd5: begin
                    fin_res = shl_w[N-1:0];
                    fin_cry = shl_w[N];
                end
                4'd6: begin
                    fin_res = shr_w[N:1];
                    fin_cry = shr_w[0];
                end
                default: fin_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            wrk   <= '0;
            cnt   <= '0;
            res_q <= '0;
            neg_q <= 1'b0;
            zr_q  <= 1'b0;
            cry_q <= 1'b0;
            of_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= bus.op;
                a_q  <= bus.a;
                b_q  <= bus.b;
                cnt  <= '0;
                wrk  <= (bus.op == 4'd7) ? {{N{1'b0}}, bus.b} : {{N{1'b0}}, bus.a};
            end else if (state == BUSY) begin
                cnt <= cnt + SW'(1);
                wrk <= wrk_step;
            end
            if (load) begin
                res_q <= fin_res;
                neg_q <= fin_res[N-1];
                zr_q  <= (fin_res == '0);
                cry_q <= fin_cry;
                of_q  <= fin_of;
                err_q <= fin_err;
            end
        end
    end
endmodule
